wb_regfile: RTL and testbench

- Write-back stage plus architectural register file of the pipelined MIPS core; consumes the outputs of the MEM/WB pipeline register.
- Selects the write-back value, commits it to a 32-entry register file, and serves two read ports to decode.
- Exports the current write-back value for EX forwarding, and keeps retire/debug state.

---
 rtl/mips_pkg.sv | 18 +
 rtl/regfile_2r1w.sv | 75 +++++++
 rtl/wb_regfile.sv | 99 +++++++++
 tb/tb_wb_regfile.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the pipelined MIPS core: datapath widths, register-file
// geometry, the fixed link register, the zero register and the nop encoding.
package mips_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NREG     = 32;
   localparam int LINK_REG = 31;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [DATA_W-1:0] NOP_IR   = 32'h0000_0000;

   // A retired word of all zeros is a pipeline bubble, not a real instruction.
   function automatic logic is_bubble(input logic [DATA_W-1:0] ir);
      return (ir == NOP_IR);
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: NREG x DATA_W, one write port, two
// asynchronous read ports. Entry 0 is never written and always reads 0.
// Optional build macro WB_BYPASS_EN: a read that hits the entry being written
// this cycle returns the write data (write-through) instead of the old value.
module regfile_2r1w
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREG   = 32
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr1,
   input  logic [ADDR_W-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2
);
   import mips_pkg::REG_ZERO;

   logic [DATA_W-1:0] r_regs [NREG];
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;

   // Array storage: async clear of every entry, qualified write never touches entry 0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != REG_ZERO)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // Read ports: zero register forced to 0, optional same-cycle write-through.
   always_comb begin
      w_rd1 = '0;
      w_rd2 = '0;
`ifdef WB_BYPASS_EN
      if (i_raddr1 == REG_ZERO) begin
         w_rd1 = '0;
      end else if (i_we && (i_raddr1 == i_waddr)) begin
         w_rd1 = i_wdata;
      end else begin
         w_rd1 = r_regs[i_raddr1];
      end
      if (i_raddr2 == REG_ZERO) begin
         w_rd2 = '0;
      end else if (i_we && (i_raddr2 == i_waddr)) begin
         w_rd2 = i_wdata;
      end else begin
         w_rd2 = r_regs[i_raddr2];
      end
`else
      if (i_raddr1 == REG_ZERO) begin
         w_rd1 = '0;
      end else begin
         w_rd1 = r_regs[i_raddr1];
      end
      if (i_raddr2 == REG_ZERO) begin
         w_rd2 = '0;
      end else begin
         w_rd2 = r_regs[i_raddr2];
      end
`endif
   end

   assign o_rdata1 = w_rd1;
   assign o_rdata2 = w_rd2;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage of the pipelined MIPS core: selects the write-back value and
// destination, qualifies the commit into the register file, exports the
// write-back value for EX forwarding, and keeps the retire counter and the last
// retired instruction. Optional build macro WB_BYPASS_EN (handled inside
// regfile_2r1w) makes a same-cycle commit visible on the read ports.
module wb_regfile
#(
   parameter int DATA_W   = 32,
   parameter int NREG     = 32,
   parameter int ADDR_W   = 5,
   parameter int LINK_REG = 31
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              iRegWrite,
   input  logic              iMemToReg,
   input  logic              iJumps,
   input  logic [DATA_W-1:0] iIR,
   input  logic [DATA_W-1:0] iReadData,
   input  logic [DATA_W-1:0] iResult,
   input  logic [ADDR_W-1:0] iRegDest,
   input  logic [ADDR_W-1:0] iReadAddr1,
   input  logic [ADDR_W-1:0] iReadAddr2,
   output logic [DATA_W-1:0] oReadData1,
   output logic [DATA_W-1:0] oReadData2,
   output logic [DATA_W-1:0] oWbData,
   output logic [ADDR_W-1:0] oWbDest,
   output logic              oWbValid,
   output logic [31:0]       oRetired,
   output logic [DATA_W-1:0] oLastIR
);
   import mips_pkg::*;

   localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

   logic [DATA_W-1:0] w_wb_data;
   logic [ADDR_W-1:0] w_wb_dest;
   logic              w_wb_valid;
   logic              w_retire;
   logic [31:0]       r_retired;
   logic [DATA_W-1:0] r_last_ir;

   // Write-back select and commit qualification; a link write overrides both data and destination.
   always_comb begin
      w_wb_data  = iResult;
      w_wb_dest  = iRegDest;
      if (iJumps) begin
         w_wb_data = iResult;
         w_wb_dest = LINK_ADDR;
      end else if (iMemToReg) begin
         w_wb_data = iReadData;
         w_wb_dest = iRegDest;
      end else begin
         w_wb_data = iResult;
         w_wb_dest = iRegDest;
      end
      w_wb_valid = enable & (iRegWrite | iJumps) & (w_wb_dest != REG_ZERO);
      w_retire   = enable & ~is_bubble(iIR);
   end

   // Retire bookkeeping: count and remember every non-bubble instruction leaving the stage.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_retired <= 32'd0;
         r_last_ir <= '0;
      end else if (w_retire) begin
         r_retired <= r_retired + 32'd1;
         r_last_ir <= iIR;
      end else begin
         r_retired <= r_retired;
         r_last_ir <= r_last_ir;
      end
   end

   regfile_2r1w #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NREG   (NREG)
   ) u_regfile (
      .clock    (clock),
      .reset    (reset),
      .i_we     (w_wb_valid),
      .i_waddr  (w_wb_dest),
      .i_wdata  (w_wb_data),
      .i_raddr1 (iReadAddr1),
      .i_raddr2 (iReadAddr2),
      .o_rdata1 (oReadData1),
      .o_rdata2 (oReadData2)
   );

   assign oWbData  = w_wb_data;
   assign oWbDest  = w_wb_dest;
   assign oWbValid = w_wb_valid;
   assign oRetired = r_retired;
   assign oLastIR  = r_last_ir;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by random
// traffic, all compared against a behavioural register-file model.
module tb_wb_regfile;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        iRegWrite;
   logic        iMemToReg;
   logic        iJumps;
   logic [31:0] iIR;
   logic [31:0] iReadData;
   logic [31:0] iResult;
   logic [4:0]  iRegDest;
   logic [4:0]  iReadAddr1;
   logic [4:0]  iReadAddr2;
   logic [31:0] oReadData1;
   logic [31:0] oReadData2;
   logic [31:0] oWbData;
   logic [4:0]  oWbDest;
   logic        oWbValid;
   logic [31:0] oRetired;
   logic [31:0] oLastIR;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_retired;
   logic [31:0] m_last_ir;

   wb_regfile dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .iRegWrite  (iRegWrite),
      .iMemToReg  (iMemToReg),
      .iJumps     (iJumps),
      .iIR        (iIR),
      .iReadData  (iReadData),
      .iResult    (iResult),
      .iRegDest   (iRegDest),
      .iReadAddr1 (iReadAddr1),
      .iReadAddr2 (iReadAddr2),
      .oReadData1 (oReadData1),
      .oReadData2 (oReadData2),
      .oWbData    (oWbData),
      .oWbDest    (oWbDest),
      .oWbValid   (oWbValid),
      .oRetired   (oRetired),
      .oLastIR    (oLastIR)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] exp_dest();
      return iJumps ? 5'd31 : iRegDest;
   endfunction

   function automatic logic [31:0] exp_data();
      if (iJumps)    return iResult;
      if (iMemToReg) return iReadData;
      return iResult;
   endfunction

   function automatic logic exp_valid();
      return enable & (iRegWrite | iJumps) & (exp_dest() != 5'd0);
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] addr);
      if (addr == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
      if ((exp_valid() === 1'b1) && (addr == exp_dest())) return exp_data();
`endif
      return m_regs[addr];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_retired = 32'd0;
      m_last_ir = 32'd0;
   endtask

   task automatic drv(input logic en, input logic rw, input logic m2r, input logic j,
                      input logic [31:0] ir, input logic [31:0] rdata, input logic [31:0] res,
                      input logic [4:0] dest, input logic [4:0] a1, input logic [4:0] a2);
      enable = en; iRegWrite = rw; iMemToReg = m2r; iJumps = j;
      iIR = ir; iReadData = rdata; iResult = res;
      iRegDest = dest; iReadAddr1 = a1; iReadAddr2 = a2;
   endtask

   // Called just after a falling edge with inputs applied: checks the
   // combinational view, crosses one rising edge, then checks retire state.
   task automatic step();
      logic        c_valid;
      logic [4:0]  c_dest;
      logic [31:0] c_data;
      logic        c_ret;
      logic [31:0] c_ir;
      #1;
      chk("wb_data",  oWbData, exp_data());
      chk("wb_dest",  {27'd0, oWbDest}, {27'd0, exp_dest()});
      chk("wb_valid", {31'd0, oWbValid}, {31'd0, exp_valid()});
      chk("rd1",      oReadData1, exp_read(iReadAddr1));
      chk("rd2",      oReadData2, exp_read(iReadAddr2));
      c_valid = exp_valid();
      c_dest  = exp_dest();
      c_data  = exp_data();
      c_ret   = (enable === 1'b1) && (iIR != 32'd0);
      c_ir    = iIR;
      @(posedge clock);
      if (c_valid === 1'b1) m_regs[c_dest] = c_data;
      if (c_ret) begin
         m_retired = m_retired + 32'd1;
         m_last_ir = c_ir;
      end
      @(negedge clock);
      chk("retired", oRetired, m_retired);
      chk("last_ir", oLastIR,  m_last_ir);
   endtask

   initial begin
      clear_model();
      reset = 1'b1;
      drv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31);
      @(negedge clock);
      @(negedge clock);
      chk("rst_rd1",     oReadData1, 32'd0);
      chk("rst_retired", oRetired,   32'd0);
      chk("rst_last_ir", oLastIR,    32'd0);
      reset = 1'b0;

      // Commit 0x1234 to r5, then reset between edges with another commit pending.
      drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h2005_1234, 32'd0, 32'h0000_1234, 5'd5, 5'd5, 5'd0);
      step();
      drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h2006_5555, 32'd0, 32'h0000_5555, 5'd6, 5'd5, 5'd6);
      #1;
      chk("pre_rst_r5", oReadData1, 32'h0000_1234);
      #2 reset = 1'b1;
      #1;
      clear_model();
      chk("mid_rst_r5",      oReadData1, 32'd0);
      chk("mid_rst_retired", oRetired,   32'd0);
      chk("mid_rst_last_ir", oLastIR,    32'd0);
      @(negedge clock);
      reset = 1'b0;
      drv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd6, 5'd5);
      step();

      // ALU result then load data into r8.
      drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0F0F_0F0F, 32'hAAAA_5555, 5'd8, 5'd8, 5'd0);
      step();
      drv(1'b1, 1'b1, 1'b1, 1'b0, 32'h8C08_0000, 32'h0F0F_0F0F, 32'hAAAA_5555, 5'd8, 5'd8, 5'd0);
      step();
      drv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd8, 5'd0);
      step();
      chk("r8_load", oReadData1, 32'h0F0F_0F0F);

      // Link write: r31 gets iResult, r4 untouched, iMemToReg ignored.
      drv(1'b1, 1'b0, 1'b1, 1'b1, 32'h0C10_0004, 32'h1111_1111, 32'h0040_0010, 5'd4, 5'd31, 5'd4);
      step();
      drv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd31, 5'd4);
      #1;
      chk("r31_link", oReadData1, 32'h0040_0010);
      chk("r4_keep",  oReadData2, 32'd0);

      // Write to r0 is dropped but still retires; a stalled write is dropped entirely.
      @(negedge clock);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h2000_FFFF, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
      step();
      drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h2009_0077, 32'd0, 32'h0000_0077, 5'd9, 5'd9, 5'd0);
      step();
      drv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'bxxxxx, 5'd9, 5'd0);
      step();
      chk("r9_stall", oReadData1, 32'd0);

      // Same-cycle read of the register being committed.
      drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h200C_0001, 32'd0, 32'h0000_0001, 5'd12, 5'd12, 5'd0);
      step();
      drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h200C_BEEF, 32'd0, 32'hDEAD_BEEF, 5'd12, 5'd12, 5'd12);
      step();
      drv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd12, 5'd0);
      step();

      // Counter wrap from all ones, then a bubble holds both retire registers.
      force dut.r_retired = 32'hFFFF_FFFF;
      #1;
      release dut.r_retired;
      m_retired = 32'hFFFF_FFFF;
      chk("wrap_preset", oRetired, 32'hFFFF_FFFF);
      @(negedge clock);
      drv(1'b1, 1'b1, 1'b1, 1'b0, 32'h8C08_0004, 32'h0000_00AB, 32'd0, 5'd8, 5'd8, 5'd0);
      step();
      chk("wrap_zero", oRetired, 32'd0);
      drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      step();
      chk("bubble_last_ir", oLastIR, 32'h8C08_0004);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic en;
         en = ($urandom_range(0, 3) != 0);
         drv(en, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom,
             $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
         if (!en && ($urandom_range(0, 7) == 0)) iRegDest = 5'bxxxxx;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
